// File: rtl/pi_filter_param.sv
// Sign-magnitude PI loop filter for the ADPLL: saturating integrator, registered
// saturated control word, hold/clear sequencing controls and a small-error lock detector.
module pi_filter_param #(
   parameter int W        = 5,
   parameter int GW       = 5,
   parameter int IW       = 10,
   parameter int OW       = 10,
   parameter int LOCK_TH  = 1,
   parameter int LOCK_CNT = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic          error_sign,
   input  logic [W-1:0]  error,
   input  logic [GW-1:0] alpha_var,
   input  logic [GW-1:0] beta_var,
   input  logic          hold,
   input  logic          clear,
   output logic [IW-1:0] integ_out,
   output logic          integ_sign,
   output logic [OW-1:0] filter_out,
   output logic          filter_sign,
   output logic          out_valid,
   output logic          sat,
   output logic          locked
);

   localparam int PW = W + GW;
   localparam int MW = ((IW > OW) ? IW : OW) + 1;
   localparam int CW = $clog2(LOCK_CNT + 1);
   localparam logic [MW-1:0] IMAX    = {{(MW-IW){1'b0}}, {IW{1'b1}}};
   localparam logic [MW-1:0] OMAX    = {{(MW-OW){1'b0}}, {OW{1'b1}}};
   localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_CNT);

   // Returns {clip, sign, magnitude}; operands are below 2^(MW-1) so the raw sum never wraps.
   function automatic logic [MW+1:0] sm_add(
      input logic          sa,
      input logic [MW-1:0] ma,
      input logic          sb,
      input logic [MW-1:0] mb,
      input logic [MW-1:0] lim
   );
      logic [MW-1:0] mag;
      logic          sgn;
      logic          clip;
      if (sa == sb) begin
         mag = ma + mb;
         sgn = sa;
      end else if (ma >= mb) begin
         mag = ma - mb;
         sgn = sa;
      end else begin
         mag = mb - ma;
         sgn = sb;
      end
      clip = 1'b0;
      if (mag > lim) begin
         mag  = lim;
         clip = 1'b1;
      end
      if (mag == '0) sgn = 1'b0;
      return {clip, sgn, mag};
   endfunction

   logic [IW-1:0] r_integ;
   logic          r_integ_sign;
   logic [OW-1:0] r_filter;
   logic          r_filter_sign;
   logic          r_out_valid;
   logic          r_sat;
   logic          r_locked;
   logic [CW-1:0] r_cnt;

   logic [PW-1:0] w_inc;
   logic [PW-1:0] w_prop;
   logic [MW+1:0] w_iadd;
   logic [MW+1:0] w_fadd;
   logic [IW-1:0] w_integ_nx;
   logic          w_integ_sign_nx;
   logic          w_iclip;
   logic          w_in_th;
   logic [CW-1:0] w_cnt_nx;

   assign w_inc  = PW'(error) * PW'(alpha_var);
   assign w_prop = PW'(error) * PW'(beta_var);

   assign w_iadd          = sm_add(r_integ_sign, MW'(r_integ), error_sign, MW'(w_inc), IMAX);
   assign w_integ_nx      = hold ? r_integ      : w_iadd[IW-1:0];
   assign w_integ_sign_nx = hold ? r_integ_sign : w_iadd[MW];
   assign w_iclip         = ~hold & w_iadd[MW+1];

   // The output sums against the updated integrator, so the current sample's integral term shows at once.
   assign w_fadd = sm_add(error_sign, MW'(w_prop), w_integ_sign_nx, MW'(w_integ_nx), OMAX);

   assign w_in_th  = (32'(error) <= 32'(LOCK_TH));
   assign w_cnt_nx = !w_in_th ? '0 :
                     (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

   // in_valid is a one-cycle strobe with no backpressure; out_valid pulses the cycle after each accepted sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_integ       <= '0;
         r_integ_sign  <= 1'b0;
         r_filter      <= '0;
         r_filter_sign <= 1'b0;
         r_out_valid   <= 1'b0;
         r_sat         <= 1'b0;
         r_locked      <= 1'b0;
         r_cnt         <= '0;
      end else if (clear) begin
         r_integ       <= '0;
         r_integ_sign  <= 1'b0;
         r_filter      <= '0;
         r_filter_sign <= 1'b0;
         r_out_valid   <= 1'b0;
         r_sat         <= 1'b0;
         r_locked      <= 1'b0;
         r_cnt         <= '0;
      end else if (in_valid) begin
         r_integ       <= w_integ_nx;
         r_integ_sign  <= w_integ_sign_nx;
         r_filter      <= w_fadd[OW-1:0];
         r_filter_sign <= w_fadd[MW];
         r_out_valid   <= 1'b1;
         r_sat         <= w_iclip | w_fadd[MW+1];
         r_locked      <= (w_cnt_nx == CNT_MAX);
         r_cnt         <= w_cnt_nx;
      end else begin
         r_out_valid   <= 1'b0;
      end
   end

   assign integ_out   = r_integ;
   assign integ_sign  = r_integ_sign;
   assign filter_out  = r_filter;
   assign filter_sign = r_filter_sign;
   assign out_valid   = r_out_valid;
   assign sat         = r_sat;
   assign locked      = r_locked;

endmodule

// File: tb/tb_pi_filter_param.sv
// Self-checking bench for pi_filter_param: signed-integer reference model feeding an
// expected-result queue, one task per scenario.
module tb_pi_filter_param;

   localparam int W        = 5;
   localparam int GW       = 5;
   localparam int IW       = 10;
   localparam int OW       = 10;
   localparam int LOCK_TH  = 1;
   localparam int LOCK_CNT = 4;
   localparam int IMAX     = 1023;
   localparam int OMAX     = 1023;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic          error_sign;
   logic [W-1:0]  error;
   logic [GW-1:0] alpha_var;
   logic [GW-1:0] beta_var;
   logic          hold;
   logic          clear;
   logic [IW-1:0] integ_out;
   logic          integ_sign;
   logic [OW-1:0] filter_out;
   logic          filter_sign;
   logic          out_valid;
   logic          sat;
   logic          locked;

   pi_filter_param #(
      .W(W), .GW(GW), .IW(IW), .OW(OW), .LOCK_TH(LOCK_TH), .LOCK_CNT(LOCK_CNT)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .error_sign(error_sign),
      .error(error), .alpha_var(alpha_var), .beta_var(beta_var), .hold(hold),
      .clear(clear), .integ_out(integ_out), .integ_sign(integ_sign),
      .filter_out(filter_out), .filter_sign(filter_sign), .out_valid(out_valid),
      .sat(sat), .locked(locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   logic [23:0] exp_q[$];
   int m_integ = 0;
   int m_cnt   = 0;

   // Observed word: {integ_sign, integ_out, filter_sign, filter_out, sat, locked}
   function automatic logic [23:0] dut_word();
      return {integ_sign, integ_out, filter_sign, filter_out, sat, locked};
   endfunction

   function automatic void clip_add(input int a, input int b, input int lim,
                                    output int r, output bit c);
      int s;
      s = a + b;
      c = 1'b0;
      r = s;
      if (s > lim) begin r = lim; c = 1'b1; end
      if (s < -lim) begin r = -lim; c = 1'b1; end
   endfunction

   function automatic void model_step(input bit s, input int e, input int a,
                                      input int b, input bit h);
      int inc, prop, ni, nf, ai, af;
      bit c1, c2;
      logic [IW-1:0] mi;
      logic [OW-1:0] mf;
      inc  = e * a;
      prop = e * b;
      c1   = 1'b0;
      ni   = m_integ;
      if (!h) clip_add(m_integ, s ? -inc : inc, IMAX, ni, c1);
      clip_add(s ? -prop : prop, ni, OMAX, nf, c2);
      m_integ = ni;
      if (e <= LOCK_TH) begin
         if (m_cnt < LOCK_CNT) m_cnt++;
      end else begin
         m_cnt = 0;
      end
      ai = (ni < 0) ? -ni : ni;
      af = (nf < 0) ? -nf : nf;
      mi = IW'(ai);
      mf = OW'(af);
      exp_q.push_back({(ni < 0), mi, (nf < 0), mf, (c1 | c2), (m_cnt == LOCK_CNT)});
   endfunction

   task automatic send(input bit s, input int e, input int a, input int b, input bit h);
      error_sign = s;
      error      = W'(e);
      alpha_var  = GW'(a);
      beta_var   = GW'(b);
      hold       = h;
      clear      = 1'b0;
      in_valid   = 1'b1;
      model_step(s, e, a, b, h);
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      hold     = 1'b0;
      clear    = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_clear();
      clear    = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      clear   = 1'b0;
      m_integ = 0;
      m_cnt   = 0;
   endtask

   task automatic test_reset();
      n_checks++;
      if ({dut_word(), out_valid} !== 25'd0) begin
         n_errors++;
         $display("FAIL reset_state: got %h expected 0", {dut_word(), out_valid});
      end
   endtask

   task automatic test_basic();
      logic [23:0] exp;
      send(1'b0, 5, 2, 3, 1'b0);
      exp = exp_q.pop_front();
      n_checks++;
      if (dut_word() !== exp) begin
         n_errors++;
         $display("FAIL basic_pos: got %h expected %h", dut_word(), exp);
      end
      n_checks++;
      if ({integ_sign, integ_out, filter_sign, filter_out, out_valid} !== {1'b0, 10'd10, 1'b0, 10'd25, 1'b1}) begin
         n_errors++;
         $display("FAIL basic_pos_const: got integ %0d filter %0d ov %b expected 10+ 25+ 1", integ_out, filter_out, out_valid);
      end
      send(1'b1, 5, 2, 3, 1'b0);
      exp = exp_q.pop_front();
      n_checks++;
      if (dut_word() !== exp || {integ_sign, integ_out, filter_sign, filter_out} !== {1'b0, 10'd0, 1'b1, 10'd15}) begin
         n_errors++;
         $display("FAIL basic_neg: got %h expected %h (integ 0+, filter 15-)", dut_word(), exp);
      end
      idle();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL basic_ov_drop: got %b expected 0", out_valid);
      end
   endtask

   task automatic test_sat();
      logic [23:0] exp;
      int exp_integ[4] = '{961, 1023, 1023, 62};
      bit exp_sat[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
      do_clear();
      for (int i = 0; i < 4; i++) begin
         send((i == 3), 31, 31, 0, 1'b0);
         exp = exp_q.pop_front();
         n_checks++;
         if (dut_word() !== exp || int'(integ_out) != exp_integ[i] || integ_sign !== 1'b0 || sat !== exp_sat[i]) begin
            n_errors++;
            $display("FAIL sat[%0d]: got %h (integ %0d sat %b) expected %h (integ %0d sat %b)",
                     i, dut_word(), integ_out, sat, exp, exp_integ[i], exp_sat[i]);
         end
      end
      idle();
   endtask

   task automatic test_hold();
      logic [23:0] exp;
      do_clear();
      send(1'b0, 5, 2, 0, 1'b0);
      send(1'b1, 4, 2, 1, 1'b1);
      void'(exp_q.pop_front());
      exp = exp_q.pop_front();
      n_checks++;
      if (dut_word() !== exp || {integ_sign, integ_out, filter_sign, filter_out} !== {1'b0, 10'd10, 1'b0, 10'd6}) begin
         n_errors++;
         $display("FAIL hold_on: got %h expected %h (integ 10+, filter 6+)", dut_word(), exp);
      end
      send(1'b1, 4, 2, 1, 1'b0);
      exp = exp_q.pop_front();
      n_checks++;
      if (dut_word() !== exp || {integ_sign, integ_out, filter_sign, filter_out} !== {1'b0, 10'd2, 1'b1, 10'd2}) begin
         n_errors++;
         $display("FAIL hold_off: got %h expected %h (integ 2+, filter 2-)", dut_word(), exp);
      end
      idle();
   endtask

   task automatic test_clear();
      send(1'b0, 1, 9, 9, 1'b0);
      void'(exp_q.pop_front());
      clear      = 1'b1;
      in_valid   = 1'b1;
      error_sign = 1'b0;
      error      = 5'd7;
      @(negedge clk);
      clear    = 1'b0;
      in_valid = 1'b0;
      m_integ  = 0;
      m_cnt    = 0;
      n_checks++;
      if ({dut_word(), out_valid} !== 25'd0) begin
         n_errors++;
         $display("FAIL clear_priority: got %h expected 0", {dut_word(), out_valid});
      end
   endtask

   task automatic test_lock();
      logic [23:0] exp;
      int errs[9]    = '{1, 0, 1, 1, 2, 1, 1, 1, 1};
      bit exp_lk[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_clear();
      for (int i = 0; i < 9; i++) begin
         send(i[0], errs[i], 0, 0, 1'b0);
         exp = exp_q.pop_front();
         n_checks++;
         if (dut_word() !== exp || locked !== exp_lk[i]) begin
            n_errors++;
            $display("FAIL lock[%0d]: got %h locked %b expected %h locked %b", i, dut_word(), locked, exp, exp_lk[i]);
         end
      end
      idle();
   endtask

   task automatic test_back_to_back();
      logic [23:0] exp;
      int e;
      do_clear();
      for (int i = 0; i < 40; i++) begin
         e = (i % 3 == 0) ? $urandom_range(0, 2) : $urandom_range(0, 31);
         send(1'($urandom_range(0, 1)), e, $urandom_range(0, 31), $urandom_range(0, 31),
              ($urandom_range(0, 4) == 0));
         exp = exp_q.pop_front();
         n_checks++;
         if (dut_word() !== exp || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b[%0d]: got %h ov %b expected %h ov 1", i, dut_word(), out_valid, exp);
         end
      end
      idle();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL b2b_idle: got ov %b expected 0", out_valid);
      end
   endtask

   task automatic test_async_reset();
      logic [23:0] exp;
      send(1'b0, 9, 7, 7, 1'b0);
      void'(exp_q.pop_front());
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({dut_word(), out_valid} !== 25'd0) begin
         n_errors++;
         $display("FAIL async_reset: got %h expected 0", {dut_word(), out_valid});
      end
      in_valid = 1'b0;
      @(negedge clk);
      reset   = 1'b1;
      m_integ = 0;
      m_cnt   = 0;
      send(1'b0, 5, 2, 3, 1'b0);
      exp = exp_q.pop_front();
      n_checks++;
      if (dut_word() !== exp || {filter_sign, filter_out} !== {1'b0, 10'd25}) begin
         n_errors++;
         $display("FAIL post_reset: got %h expected %h (filter 25+)", dut_word(), exp);
      end
      idle();
   endtask

   initial begin
      reset      = 1'b0;
      in_valid   = 1'b0;
      error_sign = 1'b0;
      error      = '0;
      alpha_var  = '0;
      beta_var   = '0;
      hold       = 1'b0;
      clear      = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b1;
      @(negedge clk);
      test_basic();
      test_sat();
      test_hold();
      test_clear();
      test_lock();
      test_back_to_back();
      test_async_reset();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pi_filter_param.md
# pi_filter_param

Parametrised sign-magnitude proportional-integral loop filter for the ADPLL, successor to the fixed 5-bit PI filter. Sits between the phase detector and the DCO control-word logic. Accepts one phase-error sample per `in_valid` strobe, keeps a saturating integrator, and produces a registered, saturated control word with a valid pulse. Adds hold/clear controls for acquisition sequencing and a lock detector driven by consecutive small-error samples.

## Interface
- `W`, 5: phase-error magnitude width.
- `GW`, 5: alpha/beta gain width.
- `IW`, 10: integrator magnitude width; must be ≥ W+GW.
- `OW`, 10: filter output magnitude width; must be ≥ W+GW.
- `LOCK_TH`, 1: lock threshold on the error magnitude (inclusive).
- `LOCK_CNT`, 8: consecutive in-threshold samples required to assert lock; must be ≥ 1.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  error sample strobe; one sample is accepted per high cycle.
- `error_sign`  in  1  error sign; 1 = negative.
- `error`  in  W  error magnitude.
- `alpha_var`  in  GW  integral gain.
- `beta_var`  in  GW  proportional gain.
- `hold`  in  1  freeze the integrator; the proportional path stays live.
- `clear`  in  1  synchronous integrator clear and lock reset.
- `integ_out`, `integ_sign`  out  IW, 1  registered integrator state.
- `filter_out`, `filter_sign`  out  OW, 1  registered filter output.
- `out_valid`  out  1  one-cycle pulse; `filter_*` has been updated.
- `sat`  out  1  the last accepted sample clipped the integrator or the output.
- `locked`  out  1  lock indicator.

## Operation
- Products are unsigned magnitudes, W+GW bits, never truncated:
  - prop = error*beta_var
  - inc = error*alpha_var
- Signed add (sign-magnitude):
  - Same signs: add the magnitudes and keep the sign.
  - Opposite signs: subtract the smaller magnitude from the larger; the result takes the sign of the larger.
  - A zero result always carries sign 0 (no negative zero).
  - A magnitude above 2^N-1 clamps to 2^N-1, keeps its sign and raises the clip.
- On an accepted sample (`in_valid`=1, `clear`=0):
  - integ_next = hold ? integ : integ ⊕ (error_sign, inc), saturated to IW bits.
  - filter_next = (error_sign, prop) ⊕ integ_next, saturated to OW bits.
  - integ ← integ_next
  - filter ← filter_next
  - sat ← (either add clipped)
- `in_valid`=0 with `clear`=0: all registers hold and `out_valid`=0.
- `clear`=1, which has priority over `in_valid`:
  - integ ← 0 with sign 0; filter ← 0 with sign 0.
  - sat ← 0; lock counter ← 0; locked ← 0.
  - out_valid ← 0; the sample present in that cycle is dropped.
- Lock detector, updated only on accepted samples:
  - If error ≤ LOCK_TH, the counter increments, saturating at LOCK_CNT. Otherwise the counter and `locked` both clear in that cycle.
  - `locked` = (counter == LOCK_CNT), registered.
  - The detector runs regardless of `hold`.
- The gains are sampled on each accepted sample. Changing them between samples is legal and takes effect on the next sample.

## Timing
- Reset values: all outputs 0, including `integ_*`, `filter_*`, `out_valid`, `sat` and `locked`; internal counter 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). The first sample is accepted on the first rising edge with `reset` high.
- Latency: a sample accepted at edge k appears on `filter_*`, `integ_*` and `sat` after edge k. `out_valid` is high for the cycle following edge k.
- The integrator update and the output both use integ_next, so the output reflects the current sample's integral contribution in the same update (matches the 5-bit filter's combinational path, but registered).
- Back-to-back `in_valid` is supported at one sample per cycle; `out_valid` then stays high continuously.
- `locked` asserts after the edge accepting the LOCK_CNT-th consecutive in-threshold sample. It deasserts after the edge accepting the first out-of-threshold sample.
- `hold` and `clear` are sampled on the same edge as the data.

## Test plan
- Basic path (defaults):
  - alpha=2, beta=3; sample +5 → integ=10+, filter=25+, out_valid pulse one cycle later.
  - Then sample −5 → integ=0 with sign 0, filter=15−.
- Integrator saturation: alpha=31, beta=0; error=31+ three times → integ 961, then 1023 (sat=1), then 1023 (sat=1). Then error=31− → integ=62+ with sat=0.
- Hold: integ=10+; `hold`=1, alpha=2, beta=1, error=4− → integ stays 10+, filter=6+. Release `hold` and repeat the sample → integ=2+, filter=2− (4−⊕2+).
- Clear priority: `clear`=1 and `in_valid`=1 together → integ=0, filter=0, out_valid=0, locked=0 after the edge.
- Lock with LOCK_CNT=4, LOCK_TH=1:
  - Errors 1,0,1 give locked=0; a 4th sample of 1 gives locked=1.
  - A next error of 2 gives locked=0; it then takes 4 more good samples to relock.
- Async reset mid-stream: drop `reset` between edges → all outputs 0 immediately. The first post-reset sample +5 (alpha=2, beta=3) gives filter=25+.
